// File: rtl/maxpool_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_sequencer_if : layer-control, buffer and datapath signals (rev 1.0)|
// +----------------------------------------------------------------------------+
interface maxpool_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
);
  logic              start;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic [ADDR_W-1:0] cfg_src_base;
  logic [ADDR_W-1:0] cfg_dst_base;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pool_d1;
  logic [DATA_W-1:0] pool_d2;
  logic [DATA_W-1:0] pool_d3;
  logic [DATA_W-1:0] pool_d4;
  logic [DATA_W-1:0] pool_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  start, cfg_width, cfg_height, cfg_src_base, cfg_dst_base, rd_data, pool_result,
    output busy, done, cfg_err, rd_en, rd_addr, pool_d1, pool_d2, pool_d3, pool_d4,
           wr_en, wr_addr, wr_data
  );

  modport master (
    output start, cfg_width, cfg_height, cfg_src_base, cfg_dst_base, rd_data, pool_result,
    input  busy, done, cfg_err, rd_en, rd_addr, pool_d1, pool_d2, pool_d3, pool_d4,
           wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/maxpool_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_sequencer : 2x2 stride-2 max-pool pass controller          (rev 1.0)|
// +----------------------------------------------------------------------------+
module maxpool_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input wire logic          Clock,
  input wire logic          Reset,
  maxpool_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_POOL  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [DIM_W-1:0]  C_ONE_D = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [1:0]        r_k;
  logic [DIM_W-1:0]  r_c;
  logic [DIM_W-1:0]  r_r;
  logic [DIM_W-1:0]  r_w;
  logic [DIM_W-1:0]  r_ow;
  logic [DIM_W-1:0]  r_oh;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic              r_rd_en;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic [DATA_W-1:0] r_d3;
  logic [DATA_W-1:0] r_d4;

  logic [DIM_W-1:0]  w_ow;
  logic [DIM_W-1:0]  w_oh;
  logic              w_last_c;
  logic              w_last;
  logic [DIM_W-1:0]  w_nxt_c;
  logic [ADDR_W-1:0] w_nxt_row_base;

  // Address of pixel k of the window whose top row starts at row_base, column 2c.
  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [ADDR_W-1:0] row_base,
    input logic [DIM_W-1:0]  c,
    input logic [1:0]        k,
    input logic [DIM_W-1:0]  w
  );
    logic [ADDR_W-1:0] a;
    a = row_base + (ADDR_W'(c) << 1);
    if (k[1]) a = a + ADDR_W'(w);
    if (k[0]) a = a + C_ONE_A;
    return a;
  endfunction

  assign w_ow           = bus.cfg_width >> 1;
  assign w_oh           = bus.cfg_height >> 1;
  assign w_last_c       = (r_c == r_ow - C_ONE_D);
  assign w_last         = w_last_c && (r_r == r_oh - C_ONE_D);
  assign w_nxt_c        = w_last_c ? '0 : r_c + C_ONE_D;
  assign w_nxt_row_base = w_last_c ? r_row_base + (ADDR_W'(r_w) << 1) : r_row_base;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_c        <= '0;
      r_r        <= '0;
      r_w        <= '0;
      r_ow       <= '0;
      r_oh       <= '0;
      r_row_base <= '0;
      r_wr_ptr   <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_d4       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_w        <= bus.cfg_width;
            r_ow       <= w_ow;
            r_oh       <= w_oh;
            r_row_base <= bus.cfg_src_base;
            r_wr_ptr   <= bus.cfg_dst_base;
            r_c        <= '0;
            r_r        <= '0;
            r_k        <= '0;
            r_busy     <= 1'b1;
            if (w_ow == '0 || w_oh == '0) begin
              r_cfg_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_cfg_err <= 1'b0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.cfg_src_base;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Data for the read issued one cycle earlier lands in the previous slot.
          case (r_k)
            2'd1:    r_d1 <= bus.rd_data;
            2'd2:    r_d2 <= bus.rd_data;
            2'd3:    r_d3 <= bus.rd_data;
            default: ;
          endcase
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_rd_en <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_rd_addr <= pix_addr(r_row_base, r_c, r_k + 2'd1, r_w);
          end
        end
        S_WAIT: begin
          r_d4    <= bus.rd_data;
          r_state <= S_POOL;
        end
        S_POOL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_wr_ptr;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_ptr <= r_wr_ptr + C_ONE_A;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_c        <= w_nxt_c;
            r_r        <= w_last_c ? r_r + C_ONE_D : r_r;
            r_row_base <= w_nxt_row_base;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= pix_addr(w_nxt_row_base, w_nxt_c, 2'd0, r_w);
            r_state    <= S_FETCH;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The datapath result only becomes valid in the WRITE cycle, so it is passed through.
  assign bus.wr_data = r_wr_en ? bus.pool_result : '0;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.cfg_err = r_cfg_err;
  assign bus.pool_d1 = r_d1;
  assign bus.pool_d2 = r_d2;
  assign bus.pool_d3 = r_d3;
  assign bus.pool_d4 = r_d4;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_sequencer.sv
`default_nettype none
// tb_maxpool_sequencer: scoreboard bench with a memory model and a behavioural max-pool datapath.
module tb_maxpool_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  maxpool_sequencer_if #(.DATA_W(32), .ADDR_W(16), .DIM_W(8)) bus ();

  maxpool_sequencer #(.DATA_W(32), .ADDR_W(16), .DIM_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [65536];
  logic [15:0] exp_rd_q [$];
  logic [15:0] exp_wa_q [$];
  logic [31:0] exp_wd_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rd  = 0;
  int n_wr  = 0;

  // Source memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge Clock) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= $urandom;
  end

  // Behavioural maxpoolmodule: registered unsigned max of the four inputs.
  always @(posedge Clock) begin
    logic [31:0] m;
    m = bus.pool_d1;
    if (bus.pool_d2 > m) m = bus.pool_d2;
    if (bus.pool_d3 > m) m = bus.pool_d3;
    if (bus.pool_d4 > m) m = bus.pool_d4;
    bus.pool_result <= m;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.busy, bus.done, bus.cfg_err, bus.rd_en, bus.wr_en, bus.rd_addr, bus.wr_addr,
            bus.wr_data != 0, bus.pool_d1 != 0, bus.pool_d2 != 0, bus.pool_d3 != 0, bus.pool_d4 != 0};
  endfunction

  // Reference: window/row-major order straight from the address rules.
  task automatic model_pass(input int w, input int h, input logic [15:0] src, input logic [15:0] dst);
    int ow;
    int oh;
    logic [15:0] a;
    logic [31:0] m;
    ow = w / 2;
    oh = h / 2;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        m = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            a = 16'(int'(src) + (2 * r + dy) * w + 2 * c + dx);
            exp_rd_q.push_back(a);
            if (mem[a] > m) m = mem[a];
          end
        end
        exp_wa_q.push_back(16'(int'(dst) + r * ow + c));
        exp_wd_q.push_back(m);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a read or a write.
  always @(negedge Clock) begin
    if (!Reset) begin
      check("rd_wr_exclusive", 64'(bus.rd_en & bus.wr_en), 64'd0);
      if (bus.rd_en) begin
        n_rd++;
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: read at %0h, expected no read", bus.rd_addr);
        end else begin
          check("rd_addr", 64'(bus.rd_addr), 64'(exp_rd_q.pop_front()));
        end
      end
      if (bus.wr_en) begin
        n_wr++;
        if (exp_wa_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: write %0h to %0h, expected no write", bus.wr_data, bus.wr_addr);
        end else begin
          check("wr_addr", 64'(bus.wr_addr), 64'(exp_wa_q.pop_front()));
          check("wr_data", 64'(bus.wr_data), 64'(exp_wd_q.pop_front()));
        end
      end
    end
  end

  task automatic run_pass(input int w, input int h, input logic [15:0] src, input logic [15:0] dst,
                          input int busy_start_at, input int reset_at, input bit start_in_done);
    int nwin;
    int lat;
    bit seen;
    nwin = (w / 2) * (h / 2);
    @(negedge Clock);
    bus.cfg_width    = 8'(w);
    bus.cfg_height   = 8'(h);
    bus.cfg_src_base = src;
    bus.cfg_dst_base = dst;
    bus.start        = 1'b1;
    model_pass(w, h, src, dst);
    n_rd = 0;
    n_wr = 0;
    @(posedge Clock);
    #1;
    bus.start        = 1'b0;
    bus.cfg_width    = 8'($urandom);
    bus.cfg_height   = 8'($urandom);
    bus.cfg_src_base = 16'($urandom);
    bus.cfg_dst_base = 16'($urandom);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 1000) begin
      @(negedge Clock);
      lat++;
      if (lat == 1) begin
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("cfg_err_at_start", 64'(bus.cfg_err), 64'(nwin == 0));
      end
      if (reset_at != 0 && lat == reset_at) begin
        Reset = 1'b1;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        repeat (2) @(posedge Clock);
        #1;
        check("held_reset_outputs", all_outputs(), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        return;
      end
      if (busy_start_at != 0 && lat == busy_start_at) begin
        bus.cfg_width  = 8'd2;
        bus.cfg_height = 8'd2;
        bus.start      = 1'b1;
      end
      if (busy_start_at != 0 && lat == busy_start_at + 1) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("done_latency", 64'(lat), 64'((nwin == 0) ? 1 : 1 + 7 * nwin));
    check("cfg_err_at_done", 64'(bus.cfg_err), 64'(nwin == 0));
    if (start_in_done) begin
      bus.start = 1'b1;
      @(posedge Clock);
      #1;
      bus.start = 1'b0;
      @(negedge Clock);
      check("start_in_done_ignored", 64'({bus.busy, bus.rd_en}), 64'd0);
    end
    check("read_count", 64'(n_rd), 64'(4 * nwin));
    check("write_count", 64'(n_wr), 64'(nwin));
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wa_q.size()), 64'd0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.cfg_width    = '0;
    bus.cfg_height   = '0;
    bus.cfg_src_base = '0;
    bus.cfg_dst_base = '0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);

    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_outputs", all_outputs(), 64'd0);

    run_pass(4, 4, 16'h0000, 16'h0100, 0, 0, 1'b0);
    run_pass(5, 3, 16'h0200, 16'h0300, 0, 0, 1'b0);
    run_pass(1, 6, 16'h0040, 16'h0500, 0, 0, 1'b1);
    run_pass(2, 2, 16'hFFFE, 16'h0400, 0, 0, 1'b0);
    run_pass(4, 4, 16'h1000, 16'h2000, 15, 0, 1'b0);
    run_pass(4, 4, 16'h3000, 16'h4000, 0, 13, 1'b0);
    check("no_write_after_reset", 64'(n_wr), 64'd1);
    run_pass(4, 4, 16'h0010, 16'h0600, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_pass(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               16'($urandom), 16'($urandom), 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_sequencer.md
# maxpool_sequencer

Control block that runs a complete 2x2, stride-2 max-pool pass over one feature map held in memory. It reads each 2x2 window from a source memory, presents the four pixels to the `maxpoolmodule` datapath, and captures the datapath's registered result. It then writes the pooled value to a destination memory. It sits between the feature-map buffers and `maxpoolmodule`, and is started by the layer-level controller with a start/done handshake.

## Interface
- `DATA_W`, default 32: pixel width; must match the datapath width.
- `ADDR_W`, default 16: memory address width.
- `DIM_W`, default 8: width of the map dimension fields.

- `Clock`  in  1  system clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `cfg_width`  in  DIM_W  input map width in pixels; latched on accepted start.
- `cfg_height`  in  DIM_W  input map height in pixels; latched on accepted start.
- `cfg_src_base`  in  ADDR_W  address of input pixel (0,0); latched on accepted start.
- `cfg_dst_base`  in  ADDR_W  address of output pixel (0,0); latched on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `cfg_err`  out  1  sticky flag, set when a pass has zero windows; cleared by the next accepted start.
- `rd_en`  out  1  source read strobe.
- `rd_addr`  out  ADDR_W  source read address.
- `rd_data`  in  DATA_W  source data; valid exactly 1 cycle after `rd_en`.
- `pool_d1`..`pool_d4`  out  DATA_W each  window pixels (top-left, top-right, bottom-left, bottom-right), registered; drive `maxpoolmodule` data_1..data_4.
- `pool_result`  in  DATA_W  datapath output; valid 1 clock edge after `pool_d*` are stable.
- `wr_en`  out  1  destination write strobe.
- `wr_addr`  out  ADDR_W  destination write address.
- `wr_data`  out  DATA_W  destination write data.

## Operation
- **Window counts:**
  - OW = floor(cfg_width/2), OH = floor(cfg_height/2).
  - An odd last column or row is ignored.
- **Window order:** windows are processed row-major, with `r` in 0..OH-1 and `c` in 0..OW-1.
- **Read addresses:**
  - src_base + (2r+dy)*W + 2c + dx.
  - Order is (dy,dx) = (0,0), (0,1), (1,0), (1,1), feeding d1..d4 respectively.
  - Arithmetic is modulo 2^ADDR_W.
- **Write address:** dst_base + r*OW + c, modulo 2^ADDR_W.
- **States:**
  - IDLE: wait for `start`. On `start`, latch the config and clear `cfg_err`. If OW=0 or OH=0, set `cfg_err` and go to DONE; otherwise go to FETCH.
  - FETCH (4 cycles, k=0..3): assert `rd_en` with the address for pixel k. The `rd_data` returned from the previous cycle's read is captured into pool_d(k).
  - WAIT (1 cycle): capture the 4th `rd_data` into `pool_d4`; no read is issued.
  - POOL (1 cycle): `pool_d*` are held stable, and the datapath registers its max at the end of this cycle.
  - WRITE (1 cycle):
    - Assert `wr_en` with `wr_data` = `pool_result`.
    - Advance c. When c wraps, set c=0 and advance r.
    - Go to DONE after the last window, otherwise to FETCH.
  - DONE (1 cycle): `done`=1, then go to IDLE.
- `start` is ignored while `busy` is high. It is also ignored in the DONE cycle.
- `pool_d*` hold their last values between windows and after a pass.
- **Reset:**
  - Applies at any time, including mid-pass.
  - Returns the block to IDLE immediately.
  - All outputs go to 0, and the coordinate counters go to 0.
  - No write completes after reset asserts.

## Timing
- **Reset values:** `busy`, `done`, `cfg_err`, `rd_en`, `wr_en` = 0. `rd_addr`, `wr_addr`, `wr_data`, `pool_d1`..`pool_d4` = 0.
- **Start:** `start` is sampled at edge t0. FETCH k=0 occupies cycle t0+1, with `rd_en` high and `busy` high.
- **Per window:** 7 cycles (FETCH×4, WAIT, POOL, WRITE), with no overlap between windows.
- **Pass length:** the first `wr_en` is in cycle t0+7. `done` is in cycle t0+1+7·OW·OH. A zero-window pass pulses `done` in cycle t0+1.
- `rd_en` and `wr_en` are never high in the same cycle.
- **Strobe widths:** `rd_en` is high for exactly 4 cycles per window and `wr_en` for exactly 1.

## Test plan
- **4x4 map, values 0..15 row-major, src=0x0000, dst=0x0100:**
  - Writes 5, 7, 13, 15 to 0x100..0x103, in that order.
  - `done` pulses 29 cycles after `start`.
- **5x3 map, all pixels distinct:**
  - OW=2, OH=1: exactly 2 writes, and row 2 and column 4 are never read.
  - `rd_addr` set = {0,1,5,6,2,3,7,8} (+src).
- **1x6 config:** `cfg_err`=1, zero reads and writes, `done` one cycle after `start`. The next valid `start` clears `cfg_err`.
- **Address wrap, src_base=0xFFFE, 2x2 map:** reads go to 0xFFFE, 0xFFFF, 0x0000, 0x0001, and 1 write goes to dst_base.
- **Start while busy:**
  - Pulse `start` at the 3rd window of a 4x4 pass.
  - No restart occurs, the config is unchanged, and exactly 4 writes are made.
- **Reset mid-pass:**
  - Assert `Reset` during POOL of window 2.
  - All outputs go to 0 asynchronously, with no further `wr_en`.
  - A new `start` after release runs a full pass correctly.
